data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Responder (slave) end of the pipeline's data-SRAM request/response interface, the side that returns data_sram_rdata to the MEM stage.
- Accepts read and write requests from the EX stage on an addr_ok handshake.
- Writes are committed to an internal word-addressed memory on acceptance. Responses, read data for reads and 0 for writes, return in order on data_ok after a fixed latency.
- Used as the synthesizable data memory for pipeline bring-up and as the reference memory in pipeline benches.

Parameters:
- DEPTH_LOG2, 10: memory holds 2**DEPTH_LOG2 32-bit words.
- LATENCY, 2: cycles from request acceptance to data_ok. Minimum 1.
- QDEPTH, 4: maximum outstanding (accepted, not yet responded) requests. Minimum 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = write, 0 = read.
- data_sram_size  in  2  0 byte, 1 half, 2 word. Informational only; lanes are chosen by wstrb and by the MEM stage.
- data_sram_addr  in  32  byte address. Word index = addr[DEPTH_LOG2+1:2]. Bits [1:0] and higher bits are ignored.
- data_sram_wstrb  in  4  byte-lane write enables, used only when wr=1.
- data_sram_wdata  in  32  write data, full-word lane aligned.
- data_sram_addr_ok  out  1  request accepted this cycle when req&addr_ok.
- data_sram_data_ok  out  1  response valid, single-cycle pulse per request.
- data_sram_rdata  out  32  response data, meaningful only with data_ok.
- outstanding  out  clog2(QDEPTH+1)  current outstanding count, for debug and bench.

Behaviour:
- Reset (async, active-high): queue empty, outstanding=0, data_ok=0, rdata=0, addr_ok=0 while reset is high. Memory contents are not reset.
- Accept condition: acc = req & addr_ok.
  - addr_ok = ~reset_active & ((outstanding < QDEPTH) | data_ok). This is combinational from internal state only, never from req.
  - When full, a pop in the same cycle frees a slot, so push and pop in one cycle are legal.
- Write on acc with wr=1: for each byte i with wstrb[i]=1, mem[idx][8i+7:8i] <= wdata[8i+7:8i] at that clock edge. A queue entry is pushed with data 0.
- Read on acc with wr=0: the entry captures mem[idx] as seen before this edge, so a read accepted the cycle after a write sees the write.
  - Reads never observe writes accepted later, giving strict program order.
- Queue entry fields: {data[31:0], timer}. Timer loads LATENCY-1 on push and decrements each cycle while non-zero.
- Response: data_ok = queue non-empty & head.timer==0. rdata = head.data when data_ok, else 0.
  - The head pops on the data_ok cycle. There is no backpressure on the response side; the consumer always takes it.
- Latency: a request accepted at edge N produces data_ok during the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after the accept cycle.
  - Throughput is 1 request per cycle when QDEPTH >= LATENCY.
  - With QDEPTH < LATENCY, addr_ok deasserts when full, with no loss and no reordering.
- outstanding: +1 on acc only, -1 on pop only, unchanged on both or neither. It never exceeds QDEPTH and never underflows.
- Reset asserted mid-operation: all outstanding requests are discarded and no data_ok is issued for them. Memory writes already committed persist.
- Queue pointers wrap modulo QDEPTH. Non-power-of-two QDEPTH is supported.
- req high with addr_ok low: nothing happens. The requester must hold its request, and the block keeps no state for it.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2.
  - default LATENCY/QDEPTH constants.
  - a response-entry struct typedef {data, timer}.
- One sub-module: data_sram_resp_queue, an in-order FIFO of entries with per-entry timers, exposing push, pop, head, full and count.
- The top level holds the memory array and handshake logic.

Test Plan:
1. Reset, write addr 0x100 wdata 0x11223344 wstrb 4'b1111, then read 0x100 (LATENCY=2). Required: data_ok 2 cycles after the read is accepted, rdata=0x11223344; the write's data_ok carries rdata=0.
2. After test 1, write 0x100 wstrb 4'b0100 wdata 0x00AB0000, then read 0x100. Required: rdata=0x11AB3344.
3. Six back-to-back reads of 0x0,0x4,...,0x14, preloaded 0xA0..0xA5, with LATENCY=2 and QDEPTH=4. Required: addr_ok held 1 throughout; data_ok high for 6 consecutive cycles returning 0xA0..0xA5 in order; outstanding peaks at 2.
4. Held requests with LATENCY=6 and QDEPTH=2. Required: addr_ok drops after 2 accepts and outstanding=2; in the first head data_ok cycle, addr_ok=1, a third request is accepted, and outstanding stays 2.
5. DEPTH_LOG2=10: write 0x1000 wdata 0xDEADBEEF, then read 0x0. Required: rdata=0xDEADBEEF (alias).
6. Assert reset for 1 cycle with 3 reads outstanding. Required: no data_ok for them, and outstanding=0 immediately. After release, a read of an earlier-written address returns its stored value.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-SRAM responder.
// Entry timers count down to zero while a response waits.
package data_sram_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int DEF_DEPTH_LOG2 = 10;
  localparam int DEF_LATENCY    = 2;
  localparam int DEF_QDEPTH     = 4;
  localparam int TIMER_W        = 8;

  typedef struct packed {
    logic [31:0]        data;
    logic [TIMER_W-1:0] timer;
  } resp_entry_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/data_sram_resp_queue.sv
// In-order response FIFO; every entry carries its own latency timer.
// The head is always the oldest entry, so it always expires first.
module data_sram_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int QDEPTH  = DEF_QDEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [31:0]                  push_data,
  input  logic                         pop,
  output resp_entry_t                  head,
  output logic                         head_valid,
  output logic                         full,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int CW = $clog2(QDEPTH+1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [TIMER_W-1:0] T_LOAD = TIMER_W'(LATENCY-1);

  resp_entry_t     q [QDEPTH];
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wptr;
  logic [CW-1:0]   cnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < QDEPTH; i++)
        q[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++)
        if (q[i].timer != '0)
          q[i].timer <= q[i].timer - 1'b1;
      // A push may reuse the slot being popped this cycle.
      if (push) begin
        q[wptr].data  <= push_data;
        q[wptr].timer <= T_LOAD;
        wptr          <= nxt(wptr);
      end
      if (pop)
        rptr <= nxt(rptr);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head       = q[rptr];
  assign head_valid = (cnt != '0);
  assign full       = (cnt == CW'(QDEPTH));
  assign count      = cnt;

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word memory plus fixed-latency in-order replies.
// Writes commit at acceptance; reads snapshot memory at acceptance.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int QDEPTH     = DEF_QDEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         data_sram_req,
  input  logic                         data_sram_wr,
  input  logic [1:0]                   data_sram_size,
  input  logic [31:0]                  data_sram_addr,
  input  logic [3:0]                   data_sram_wstrb,
  input  logic [31:0]                  data_sram_wdata,
  output logic                         data_sram_addr_ok,
  output logic                         data_sram_data_ok,
  output logic [31:0]                  data_sram_rdata,
  output logic [$clog2(QDEPTH+1)-1:0]  outstanding
);

  logic [31:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  acc;
  logic                  full;
  logic                  head_valid;
  resp_entry_t           head;
  logic [31:0]           push_data;
  logic                  size_legal;
  logic                  unused_bits;

  assign idx = data_sram_addr[DEPTH_LOG2+1:2];

  assign data_sram_data_ok = head_valid & (head.timer == '0);
  assign data_sram_addr_ok = ~reset & (~full | data_sram_data_ok);
  assign acc = data_sram_req & data_sram_addr_ok;

  assign push_data = data_sram_wr ? 32'h0 : mem[idx];

  assign data_sram_rdata = data_sram_data_ok ? head.data : 32'h0;

  always_ff @(posedge clk)
    if (acc & data_sram_wr)
      mem[idx] <= strb_merge(mem[idx], data_sram_wdata, data_sram_wstrb);

  data_sram_resp_queue #(
    .QDEPTH  (QDEPTH),
    .LATENCY (LATENCY)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (acc),
    .push_data  (push_data),
    .pop        (data_sram_data_ok),
    .head       (head),
    .head_valid (head_valid),
    .full       (full),
    .count      (outstanding)
  );

  // Size and out-of-range address bits do not steer this memory.
  assign size_legal = data_sram_size inside {SZ_BYTE, SZ_HALF, SZ_WORD};
  assign unused_bits = ^{size_legal,
                         data_sram_addr[31:DEPTH_LOG2+2],
                         data_sram_addr[1:0]};

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder.
// Three instances cover the parameter sets the checks need.
module tb_data_sram_responder;

  logic clk;
  logic reset;
  logic reset_c;

  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [2:0]  outs;

  logic        req_b, wr_b;
  logic [1:0]  size_b;
  logic [31:0] addr_b, wdata_b;
  logic [3:0]  wstrb_b;
  logic        addr_ok_b, data_ok_b;
  logic [31:0] rdata_b;
  logic [1:0]  outs_b;
  logic        addr_ok_c, data_ok_c;
  logic [31:0] rdata_c;
  logic [2:0]  outs_c;

  int n_tests = 0;
  int n_fail  = 0;

  data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(2), .QDEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
    .data_sram_addr(addr), .data_sram_wstrb(wstrb),
    .data_sram_wdata(wdata),
    .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata), .outstanding(outs)
  );

  data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(6), .QDEPTH(2)) dut_b (
    .clk(clk), .reset(reset),
    .data_sram_req(req_b), .data_sram_wr(wr_b), .data_sram_size(size_b),
    .data_sram_addr(addr_b), .data_sram_wstrb(wstrb_b),
    .data_sram_wdata(wdata_b),
    .data_sram_addr_ok(addr_ok_b), .data_sram_data_ok(data_ok_b),
    .data_sram_rdata(rdata_b), .outstanding(outs_b)
  );

  data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(6), .QDEPTH(4)) dut_c (
    .clk(clk), .reset(reset_c),
    .data_sram_req(req_b), .data_sram_wr(wr_b), .data_sram_size(size_b),
    .data_sram_addr(addr_b), .data_sram_wstrb(wstrb_b),
    .data_sram_wdata(wdata_b),
    .data_sram_addr_ok(addr_ok_c), .data_sram_data_ok(data_ok_c),
    .data_sram_rdata(rdata_c), .outstanding(outs_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && outs != 3'd0; i++) cyc();
    chk({tag, "_drain"}, 32'(outs), 32'd0);
  endtask

  task automatic wr_op(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input string tag);
    chk({tag, "_aok"}, 32'(addr_ok), 32'd1);
    req = 1'b1; wr = 1'b1; addr = a; wdata = d; wstrb = s;
    cyc();
    req = 1'b0; wr = 1'b0;
    drain(tag);
  endtask

  task automatic rd_check(input logic [31:0] a, input logic [31:0] exp,
                          input string tag);
    logic seen;
    seen = 1'b0;
    chk({tag, "_aok"}, 32'(addr_ok), 32'd1);
    req = 1'b1; wr = 1'b0; addr = a;
    cyc();
    req = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (data_ok) begin
        chk({tag, "_rdata"}, rdata, exp);
        seen = 1'b1;
      end else cyc();
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    cyc();
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  exp_out [10];
    int  peak;
    logic seen;
    exp_out = '{0, 1, 2, 2, 2, 2, 2, 1, 0, 0};

    reset = 1'b1; reset_c = 1'b1;
    req = 0; wr = 0; size = 2'd2; addr = 0; wdata = 0; wstrb = 0;
    req_b = 0; wr_b = 0; size_b = 2'd2; addr_b = 0; wdata_b = 0;
    wstrb_b = 0;
    cyc(); cyc();
    chk("rst_aok", 32'(addr_ok), 32'd0);
    chk("rst_dok", 32'(data_ok), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_outs", 32'(outs), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_aok", 32'(addr_ok), 32'd1);

    // Test 1: write then read-after-write
    req = 1; wr = 1; addr = 32'h100; wdata = 32'h11223344; wstrb = 4'hF;
    cyc();
    chk("t1_aok", 32'(addr_ok), 32'd1);
    chk("t1_outs1", 32'(outs), 32'd1);
    chk("t1_dok0", 32'(data_ok), 32'd0);
    wr = 0;
    cyc();
    req = 0;
    chk("t1_wr_dok", 32'(data_ok), 32'd1);
    chk("t1_wr_rdata", rdata, 32'd0);
    chk("t1_outs2", 32'(outs), 32'd2);
    cyc();
    chk("t1_rd_dok", 32'(data_ok), 32'd1);
    chk("t1_rd_rdata", rdata, 32'h11223344);
    chk("t1_outs3", 32'(outs), 32'd1);
    cyc();
    chk("t1_idle_dok", 32'(data_ok), 32'd0);
    chk("t1_outs4", 32'(outs), 32'd0);

    // Test 2: single-lane partial write
    wr_op(32'h100, 32'h00AB0000, 4'b0100, "t2_wr");
    rd_check(32'h100, 32'h11AB3344, "t2_rd");

    // Test 3: six back-to-back reads
    for (int i = 0; i < 6; i++)
      wr_op(32'(4*i), 32'hA0 + 32'(i), 4'hF, "t3_pre");
    peak = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 6) begin
        req = 1; wr = 0; addr = 32'(4*k);
        chk($sformatf("t3_aok_%0d", k), 32'(addr_ok), 32'd1);
      end else req = 0;
      chk($sformatf("t3_dok_%0d", k), 32'(data_ok),
          32'((k >= 2 && k < 8) ? 1 : 0));
      chk($sformatf("t3_rdata_%0d", k), rdata,
          (k >= 2 && k < 8) ? 32'hA0 + 32'(k-2) : 32'd0);
      chk($sformatf("t3_outs_%0d", k), 32'(outs), 32'(exp_out[k]));
      if (int'(outs) > peak) peak = int'(outs);
      cyc();
    end
    chk("t3_peak", 32'(peak), 32'd2);

    // Test 4: full queue with held request (LATENCY=6, QDEPTH=2)
    req_b = 1; wr_b = 0; addr_b = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        chk("t4_full_aok", 32'(addr_ok_b), 32'd0);
        chk("t4_full_outs", 32'(outs_b), 32'd2);
      end
      if (k == 5) chk("t4_wait_aok", 32'(addr_ok_b), 32'd0);
      if (k == 6) begin
        chk("t4_pop_dok", 32'(data_ok_b), 32'd1);
        chk("t4_pop_aok", 32'(addr_ok_b), 32'd1);
      end
      if (k == 7) chk("t4_swap_outs", 32'(outs_b), 32'd2);
      cyc();
    end
    req_b = 0;
    for (int i = 0; i < 30 && outs_b != 2'd0; i++) cyc();
    chk("t4_drain", 32'(outs_b), 32'd0);

    // Test 5: address aliasing above DEPTH_LOG2
    wr_op(32'h1000, 32'hDEADBEEF, 4'hF, "t5_wr");
    rd_check(32'h0, 32'hDEADBEEF, "t5_rd");

    // Test 6: reset with three reads in flight (LATENCY=6, QDEPTH=4)
    reset_c = 0;
    #1;
    chk("t6_rel_aok", 32'(addr_ok_c), 32'd1);
    req_b = 1; wr_b = 1; addr_b = 32'h40; wdata_b = 32'hCAFEF00D;
    wstrb_b = 4'hF;
    cyc();
    req_b = 0; wr_b = 0;
    for (int i = 0; i < 30 && outs_c != 3'd0; i++) cyc();
    chk("t6_wr_drain", 32'(outs_c), 32'd0);
    req_b = 1; wr_b = 0; addr_b = 32'h40;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_aok_%0d", i), 32'(addr_ok_c), 32'd1);
      cyc();
    end
    req_b = 0;
    chk("t6_outs3", 32'(outs_c), 32'd3);
    reset_c = 1;
    #1;
    chk("t6_rst_outs", 32'(outs_c), 32'd0);
    chk("t6_rst_dok", 32'(data_ok_c), 32'd0);
    chk("t6_rst_aok", 32'(addr_ok_c), 32'd0);
    cyc();
    reset_c = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (data_ok_c) seen = 1'b1;
      cyc();
    end
    chk("t6_no_stale_dok", 32'(seen), 32'd0);
    req_b = 1; wr_b = 0; addr_b = 32'h40;
    cyc();
    req_b = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (data_ok_c) begin
        chk("t6_rd_rdata", rdata_c, 32'hCAFEF00D);
        seen = 1'b1;
      end else cyc();
    end
    chk("t6_rd_seen", 32'(seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
